// File: rtl/disp_demux.sv
// Loopback monitor for the multiplexed seven-segment bus: rebuilds the four
// digit values from settled {an, sseg} samples and flags illegal enables.
module disp_demux #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] valid,
  output logic       frame_tick,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int unsigned AN_W   = 4;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NDIG   = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [AN_W-1:0]  an_s1_q, an_s2_q, an_prev_q;
  logic [SEG_W-1:0] sseg_s1_q, sseg_s2_q, sseg_prev_q;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NDIG-1:0]  seen_q, seen_d;
  logic [NDIG-1:0]  valid_q, valid_d;
  logic [SEG_W-1:0] out_q [NDIG];
  logic [SEG_W-1:0] out_d [NDIG];
  logic             frame_tick_q, frame_tick_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             chg_c;
  logic             hit_c;
  logic             blank_c;
  logic [1:0]       idx_c;
  logic [NDIG-1:0]  seen_set_c;

  // Two-flop synchronizer plus previous-sample register; all idle at blank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1_q     <= 4'b1111;
      an_s2_q     <= 4'b1111;
      an_prev_q   <= 4'b1111;
      sseg_s1_q   <= 8'hFF;
      sseg_s2_q   <= 8'hFF;
      sseg_prev_q <= 8'hFF;
    end else begin
      an_s1_q     <= an_in;
      an_s2_q     <= an_s1_q;
      an_prev_q   <= an_s2_q;
      sseg_s1_q   <= sseg_in;
      sseg_s2_q   <= sseg_s1_q;
      sseg_prev_q <= sseg_s2_q;
    end
  end

  assign chg_c = ({an_s2_q, sseg_s2_q} != {an_prev_q, sseg_prev_q});

  // Enable decode: one-hot-low selects a digit, all-high is blank.
  always_comb begin
    hit_c   = 1'b0;
    blank_c = 1'b0;
    idx_c   = 2'd0;
    case (an_s2_q)
      4'b1110: begin hit_c = 1'b1; idx_c = 2'd0; end
      4'b1101: begin hit_c = 1'b1; idx_c = 2'd1; end
      4'b1011: begin hit_c = 1'b1; idx_c = 2'd2; end
      4'b0111: begin hit_c = 1'b1; idx_c = 2'd3; end
      4'b1111: blank_c = 1'b1;
      default: ;
    endcase
  end

  // Settle FSM and the single action taken when a sample has been stable.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    valid_d      = valid_q;
    out_d        = out_q;
    frame_tick_d = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    seen_set_c   = seen_q;

    case (state_q)
      ST_WAIT: begin
        if (chg_c) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          if (hit_c) begin
            out_d[idx_c]   = sseg_s2_q;
            valid_d[idx_c] = 1'b1;
            seen_set_c     = seen_q | (4'b0001 << idx_c);
            if (seen_set_c == 4'b1111) begin
              frame_tick_d = 1'b1;
              seen_d       = '0;
            end else begin
              seen_d = seen_set_c;
            end
          end else if (!blank_c) begin
            err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (chg_c) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      seen_q       <= '0;
      valid_q      <= '0;
      frame_tick_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      for (int i = 0; i < NDIG; i++) out_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      valid_q      <= valid_d;
      frame_tick_q <= frame_tick_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      out_q        <= out_d;
    end
  end

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign valid      = valid_q;
  assign frame_tick = frame_tick_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_disp_demux.sv
// Bench for disp_demux: hand tables and corner sequences plus random drive,
// with every cycle compared against a run-length model of the display bus.
module tb_disp_demux;

  localparam int unsigned SETTLE = 4;

  logic       clk;
  logic       reset;
  logic [3:0] an_in;
  logic [7:0] sseg_in;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       frame_tick;
  logic       err;
  logic [7:0] err_cnt;

  disp_demux #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .sseg_in(sseg_in),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .frame_tick(frame_tick), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sample held for SETTLE+1 input edges acts two edges later.
  typedef struct packed { logic v; logic [3:0] an; logic [7:0] ss; } act_t;

  logic [7:0] m_out [4] = '{default: 8'h00};
  logic [3:0] m_valid = '0, m_seen = '0;
  logic [7:0] m_errc = '0;
  logic       m_ft = 1'b0, m_err = 1'b0;
  logic [3:0] m_last_an = 4'hF;
  logic [7:0] m_last_ss = 8'hFF;
  int         m_run = 0;
  act_t       m_p1 = '0, m_p2 = '0;

  function automatic int digit_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      m_valid = '0; m_seen = '0; m_errc = '0; m_ft = 1'b0; m_err = 1'b0;
      m_last_an = 4'hF; m_last_ss = 8'hFF; m_run = 0; m_p1 = '0; m_p2 = '0;
    end else begin
      m_ft = 1'b0;
      m_err = 1'b0;
      if (m_p2.v) begin
        if (digit_of(m_p2.an) >= 0) begin
          m_out[digit_of(m_p2.an)] = m_p2.ss;
          m_valid[digit_of(m_p2.an)] = 1'b1;
          m_seen[digit_of(m_p2.an)] = 1'b1;
          if (m_seen == 4'hF) begin m_ft = 1'b1; m_seen = '0; end
        end else if (m_p2.an != 4'hF) begin
          m_err = 1'b1;
          if (m_errc < 8'd255) m_errc = m_errc + 8'd1;
        end
      end
      m_p2 = m_p1;
      if (an_in == m_last_an && sseg_in == m_last_ss) m_run = m_run + 1;
      else begin m_run = 1; m_last_an = an_in; m_last_ss = sseg_in; end
      m_p1 = '{v: (m_run == int'(SETTLE) + 1), an: an_in, ss: sseg_in};
    end
  end

  int errors = 0, checks = 0;
  int ft_cnt = 0, err_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, then the whole output bundle against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ({out0, out1, out2, out3, valid, frame_tick, err, err_cnt} !==
        {m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_ft, m_err, m_errc}) begin
      errors++;
      $display("FAIL model: got o=%h %h %h %h v=%b ft=%b e=%b ec=%0d expected o=%h %h %h %h v=%b ft=%b e=%b ec=%0d at %0t",
               out0, out1, out2, out3, valid, frame_tick, err, err_cnt,
               m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_ft, m_err, m_errc, $time);
    end
    if (frame_tick) ft_cnt++;
    if (err) err_pulses++;
  endtask

  task automatic apply(input logic [3:0] a, input logic [7:0] s, input int hold);
    an_in = a;
    sseg_in = s;
    repeat (hold) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] an; logic [7:0] ss; int hold;
    logic [7:0] o0, o1, o2, o3; logic [3:0] v; logic [7:0] ec; int frames;
  } vec_t;

  vec_t tbl [17];
  int   ft0, ep0;
  logic [3:0] a;

  initial begin
    tbl[0]  = '{4'hE, 8'h3F, 20, 8'h3F, 8'h00, 8'h00, 8'h00, 4'b0001, 8'd0, 0};
    tbl[1]  = '{4'hD, 8'h06, 20, 8'h3F, 8'h06, 8'h00, 8'h00, 4'b0011, 8'd0, 0};
    tbl[2]  = '{4'hB, 8'h5B, 20, 8'h3F, 8'h06, 8'h5B, 8'h00, 4'b0111, 8'd0, 0};
    tbl[3]  = '{4'h7, 8'h4F, 20, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 1};
    tbl[4]  = '{4'hE, 8'h3F, 20, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 1};
    tbl[5]  = '{4'hD, 8'h06, 20, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 1};
    tbl[6]  = '{4'hB, 8'h5B, 20, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 1};
    tbl[7]  = '{4'h7, 8'h4F, 20, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 2};
    tbl[8]  = '{4'hE, 8'h77,  3, 8'h3F, 8'h06, 8'h5B, 8'h4F, 4'b1111, 8'd0, 2};
    tbl[9]  = '{4'hD, 8'h7C, 10, 8'h3F, 8'h7C, 8'h5B, 8'h4F, 4'b1111, 8'd0, 2};
    tbl[10] = '{4'hC, 8'h00, 12, 8'h3F, 8'h7C, 8'h5B, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[11] = '{4'hF, 8'hFF, 50, 8'h3F, 8'h7C, 8'h5B, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[12] = '{4'hE, 8'h11, 10, 8'h11, 8'h7C, 8'h5B, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[13] = '{4'hE, 8'h22, 10, 8'h22, 8'h7C, 8'h5B, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[14] = '{4'hD, 8'h55, 10, 8'h22, 8'h55, 8'h5B, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[15] = '{4'hB, 8'h66, 10, 8'h22, 8'h55, 8'h66, 8'h4F, 4'b1111, 8'd1, 2};
    tbl[16] = '{4'h7, 8'h77, 10, 8'h22, 8'h55, 8'h66, 8'h77, 4'b1111, 8'd1, 3};

    reset = 1'b1;
    an_in = 4'hF;
    sseg_in = 8'hFF;
    #1;
    chk("reset_outs", {out0, out1, out2, out3}, 32'h0);
    chk("reset_flags", {valid, frame_tick, err, err_cnt}, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Rotation, glitch, illegal, blank and repeat-digit table.
    ft0 = ft_cnt;
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].an, tbl[i].ss, tbl[i].hold);
      chk($sformatf("tbl%0d_out0", i), 32'(out0), 32'(tbl[i].o0));
      chk($sformatf("tbl%0d_out1", i), 32'(out1), 32'(tbl[i].o1));
      chk($sformatf("tbl%0d_out2", i), 32'(out2), 32'(tbl[i].o2));
      chk($sformatf("tbl%0d_out3", i), 32'(out3), 32'(tbl[i].o3));
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_errcnt", i), 32'(err_cnt), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_frames", i), 32'(ft_cnt - ft0), 32'(tbl[i].frames));
    end

    // Glitch straight after reset.
    do_reset();
    ep0 = err_pulses;
    apply(4'hE, 8'h77, 3);
    apply(4'hD, 8'h7C, 10);
    chk("glitch_out0", 32'(out0), 32'h00);
    chk("glitch_out1", 32'(out1), 32'h7C);
    chk("glitch_valid", 32'(valid), 32'b0010);
    chk("glitch_err", 32'(err_pulses - ep0), 32'd0);

    // Reset during the last digit's settle window drops the partial frame.
    do_reset();
    apply(4'hE, 8'h01, 20);
    apply(4'hD, 8'h02, 20);
    apply(4'hB, 8'h03, 20);
    apply(4'h7, 8'h04, 3);
    reset = 1'b1;
    #1;
    chk("midrst_outs", {out0, out1, out2, out3}, 32'h0);
    chk("midrst_flags", {valid, frame_tick, err, err_cnt}, 32'h0);
    tick();
    reset = 1'b0;
    ft0 = ft_cnt;
    repeat (20) tick();
    chk("midrst_out3", 32'(out3), 32'h04);
    chk("midrst_valid", 32'(valid), 32'b1000);
    apply(4'hE, 8'h01, 20);
    apply(4'hD, 8'h02, 20);
    chk("midrst_noframe", 32'(ft_cnt - ft0), 32'd0);
    an_in = 4'hB;
    sseg_in = 8'h03;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("latency_ft_e%0d", k - 1), 32'(frame_tick), 32'(k == 7));
    end
    chk("midrst_frame", 32'(ft_cnt - ft0), 32'd1);

    // Illegal enables: single pulse, then saturation.
    do_reset();
    an_in = 4'hC;
    sseg_in = 8'h5A;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("illegal_err_e%0d", k - 1), 32'(err), 32'(k == 7));
    end
    chk("illegal_cnt", 32'(err_cnt), 32'd1);
    chk("illegal_outs", {out0, out1, out2, out3}, 32'h0);
    ep0 = err_pulses;
    for (int n = 0; n < 300; n++) begin
      do a = 4'($urandom_range(0, 15)); while (digit_of(a) >= 0 || a == 4'hF);
      apply(a, 8'($urandom), 6);
      apply(4'hF, 8'hFF, 6);
    end
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    chk("sat_pulses", 32'(err_pulses - ep0), 32'd300);
    chk("sat_valid", 32'(valid), 32'b0000);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0, 1: a = ~(4'b0001 << $urandom_range(0, 3));
        2:    a = 4'hF;
        default: a = 4'($urandom_range(0, 15));
      endcase
      apply(a, 8'($urandom), int'($urandom_range(1, 9)));
    end
    apply(4'hF, 8'hFF, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_demux.md
Name: disp_demux

Overview:
- Receiving end of the multiplexed seven-segment display bus: samples the active-low digit enables (an) and the segment bus (sseg), and reconstructs the four 8-bit digit values.
- Used as an on-chip loopback monitor and self-check for the display driver path.
- Also detects illegal enable patterns and reports when a full refresh frame has been captured.

Parameters:
- SETTLE, 4: number of cycles the synchronized {an,sseg} pair must be unchanged before capture; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- an_in  input  4  digit enables, active low, one-hot-low when legal
- sseg_in  input  8  segment bus
- out0  output  8  registered last captured value for digit 0 (an=1110)
- out1  output  8  same, digit 1 (an=1101)
- out2  output  8  same, digit 2 (an=1011)
- out3  output  8  same, digit 3 (an=0111)
- valid  output  4  bit i set once digit i has been captured since reset
- frame_tick  output  1  one-cycle pulse when all four digits have been captured since the last pulse
- err  output  1  one-cycle pulse on a settled illegal an pattern
- err_cnt  output  8  saturating count of err pulses

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: out0..out3=0, valid=0, frame_tick=0, err=0, err_cnt=0, internal seen mask=0, stability counter=0, state=WAIT.
- Synchronizer: two flops on an_in and sseg_in; these flops reset to an=4'b1111, sseg=8'hFF.
- prev register: holds the previous synchronized pair and resets to the same values.
- Change detect: chg = (sync pair != prev).
- FSM, two states:
  - WAIT: if chg, cnt<=0 and stay in WAIT. Else if cnt==SETTLE-1, perform the settle action and go to HELD. Else cnt<=cnt+1.
  - HELD: if chg, cnt<=0 and go to WAIT; otherwise stay. No repeat action while held.
- Settle action, by decoded synchronized an:
  - 1110/1101/1011/0111: load sseg into out0/1/2/3; set valid[i] and seen[i].
  - 1111 (blank): no action, no error.
  - Any other pattern: err=1 for one cycle; err_cnt+1, saturating at 255 (no wrap).
- Frame: if a capture makes seen==4'b1111, frame_tick=1 on the same edge as that out update, and seen<=0 (the current bit is not retained).
- Repeat captures: recapturing a digit already in seen updates its out register but does not advance the frame.
- Latency:
  - Input change that then holds stable, with E0 the first clk edge after the change: out update, frame_tick or err occurs at edge E0+SETTLE+2.
  - With SETTLE=1, the action happens at the edge after the change is detected.
- Glitches: any change shorter than SETTLE synchronized cycles causes no capture and no err; the counter restarts.
- Exclusivity: err and capture never occur in the same cycle; frame_tick only coincides with a capture.
- Reset mid-operation: all state clears immediately, including a partially counted settle and a partial frame.
- Widths: cnt is 8 bits. Arithmetic is unsigned. The err_cnt saturation compare is against 8'hFF.

Test Plan:
- Rotating drive, SETTLE=4: digits 0..3 with sseg 0x3F,0x06,0x5B,0x4F, each held 20 cycles -> out0..3 match exactly; valid=1111 after the first rotation; frame_tick exactly once per rotation, at edge E0+6 of the digit-3 interval.
- Glitch, SETTLE=4: an=1110, sseg=0x77 held 3 cycles, then an=1101, sseg=0x7C held 10 -> out0 unchanged (0), out1=0x7C, err never asserted.
- Illegal pattern: an=1100 held 12 cycles -> exactly one err pulse at E0+6, err_cnt=1, outs unchanged. Then 300 alternating illegal/blank events -> err_cnt=255 and holds.
- Blank: an=1111 held 50 cycles -> no capture, no err, seen unchanged.
- Reset mid-frame: capture digits 0..2, pulse reset for 1 cycle during digit 3's settle window -> all outputs 0 immediately; the next frame_tick requires all four digits to be recaptured.
- Repeat digit: sequence 0,0,1,2,3 -> a single frame_tick on the digit-3 capture; out0 holds the second digit-0 value.
